// File: rtl/active_list_pkg.sv
// Shared active-list types and sizing for rename, issue, LSQ and retire.
package active_list_pkg;

  localparam int AL_DEPTH      = 32;
  localparam int AL_ID_WIDTH   = 5;
  localparam int AL_ARCH_WIDTH = 5;
  localparam int AL_PHYS_WIDTH = 6;

  typedef struct packed {
    logic                     uses_rw;
    logic [AL_ARCH_WIDTH-1:0] rw_addr;
    logic [AL_PHYS_WIDTH-1:0] new_phys;
    logic [AL_PHYS_WIDTH-1:0] old_phys;
  } active_list_entry_t;

  // Age compare relative to head: true when id is strictly younger than ref_id.
  function automatic logic is_younger(
    input logic [AL_ID_WIDTH-1:0] id,
    input logic [AL_ID_WIDTH-1:0] ref_id,
    input logic [AL_ID_WIDTH-1:0] head
  );
    logic [AL_ID_WIDTH-1:0] age_id;
    logic [AL_ID_WIDTH-1:0] age_ref;
    age_id  = id - head;
    age_ref = ref_id - head;
    return age_id > age_ref;
  endfunction

endpackage

// File: rtl/active_list.sv
// In-order completion tracker: allocate at tail, mark done by id,
// squash younger on flush, retire oldest done entry each cycle.
module active_list
  import active_list_pkg::*;
#(
  parameter int DEPTH      = AL_DEPTH,
  parameter int ID_WIDTH   = AL_ID_WIDTH,
  parameter int ARCH_WIDTH = AL_ARCH_WIDTH,
  parameter int PHYS_WIDTH = AL_PHYS_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_alloc_valid,
  input  logic                  i_alloc_uses_rw,
  input  logic [ARCH_WIDTH-1:0] i_alloc_rw_addr,
  input  logic [PHYS_WIDTH-1:0] i_alloc_new_phys,
  input  logic [PHYS_WIDTH-1:0] i_alloc_old_phys,
  output logic [ID_WIDTH-1:0]   o_alloc_id,
  output logic                  o_alloc_ready,
  input  logic                  i_alu_done_valid,
  input  logic [ID_WIDTH-1:0]   i_alu_done_id,
  input  logic                  i_mem_done_valid,
  input  logic [ID_WIDTH-1:0]   i_mem_done_id,
  input  logic                  i_flush_valid,
  input  logic [ID_WIDTH-1:0]   i_flush_id,
  output logic                  o_retire_valid,
  output logic [ID_WIDTH-1:0]   o_retire_id,
  output logic                  o_retire_uses_rw,
  output logic [ARCH_WIDTH-1:0] o_retire_rw_addr,
  output logic [PHYS_WIDTH-1:0] o_retire_new_phys,
  output logic [PHYS_WIDTH-1:0] o_retire_old_phys,
  output logic                  o_empty,
  output logic [ID_WIDTH:0]     o_count
);

  localparam logic [ID_WIDTH:0] FULL_CNT = (ID_WIDTH+1)'(DEPTH);

  active_list_entry_t      ent_q [DEPTH];
  logic [DEPTH-1:0]        valid_q;
  logic [DEPTH-1:0]        done_q;
  logic [ID_WIDTH-1:0]     head_q;
  logic [ID_WIDTH-1:0]     tail_q;
  logic [ID_WIDTH:0]       cnt_q;

  logic                    alloc_ok;
  logic                    flush_ok;
  logic                    ret;
  logic [DEPTH-1:0]        squash;
  logic [DEPTH-1:0]        done_set;
  logic [ID_WIDTH-1:0]     tail_d;
  logic [ID_WIDTH:0]       cnt_d;
  logic [ID_WIDTH-1:0]     flush_age;
  active_list_entry_t      head_ent;

  assign o_alloc_ready = cnt_q != FULL_CNT;
  assign o_alloc_id    = tail_q;
  assign o_count       = cnt_q;
  assign o_empty       = cnt_q == '0;

  assign alloc_ok = i_alloc_valid & o_alloc_ready & ~i_flush_valid;
  assign flush_ok = i_flush_valid & valid_q[i_flush_id];
  assign ret      = valid_q[head_q] & done_q[head_q];
  assign head_ent = ent_q[head_q];

  assign o_retire_valid    = ret;
  assign o_retire_id       = ret ? head_q : '0;
  assign o_retire_uses_rw  = ret & head_ent.uses_rw;
  assign o_retire_rw_addr  = ret ? head_ent.rw_addr : '0;
  assign o_retire_new_phys = ret ? head_ent.new_phys : '0;
  assign o_retire_old_phys = ret ? head_ent.old_phys : '0;

  always_comb begin
    squash   = '0;
    done_set = '0;
    for (int i = 0; i < DEPTH; i++) begin
      squash[i] = flush_ok &
        is_younger(ID_WIDTH'(i), i_flush_id, head_q);
      done_set[i] = valid_q[i] & ~squash[i] & (
        (i_alu_done_valid & (i_alu_done_id == ID_WIDTH'(i))) |
        (i_mem_done_valid & (i_mem_done_id == ID_WIDTH'(i))));
    end
  end

  // A flush recomputes occupancy from the surviving span head..flush_id.
  always_comb begin
    flush_age = i_flush_id - head_q;
    tail_d    = tail_q;
    cnt_d     = cnt_q;
    unique case (1'b1)
      flush_ok: begin
        tail_d = i_flush_id + 1'b1;
        cnt_d  = {1'b0, flush_age} + 1'b1 - {{ID_WIDTH{1'b0}}, ret};
      end
      default: begin
        if (alloc_ok) tail_d = tail_q + 1'b1;
        cnt_d = cnt_q + {{ID_WIDTH{1'b0}}, alloc_ok}
                      - {{ID_WIDTH{1'b0}}, ret};
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_q & ~squash;
      done_q  <= done_q | done_set;
      if (ret) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (alloc_ok) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
      end
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_ok) begin
      ent_q[tail_q].uses_rw  <= i_alloc_uses_rw;
      ent_q[tail_q].rw_addr  <= i_alloc_rw_addr;
      ent_q[tail_q].new_phys <= i_alloc_new_phys;
      ent_q[tail_q].old_phys <= i_alloc_old_phys;
    end
  end

  a_count_bound: assert property (
    @(posedge clk) disable iff (rst) cnt_q <= FULL_CNT);
  a_no_alloc_full: assert property (
    @(posedge clk) disable iff (rst) !(alloc_ok && !o_alloc_ready));
  a_flush_valid: assert property (
    @(posedge clk) disable iff (rst)
    i_flush_valid |-> valid_q[i_flush_id]);
  a_alu_done_valid: assert property (
    @(posedge clk) disable iff (rst)
    (i_alu_done_valid && !i_flush_valid) |-> valid_q[i_alu_done_id])
    else $warning("alu completion to invalid entry");
  a_mem_done_valid: assert property (
    @(posedge clk) disable iff (rst)
    (i_mem_done_valid && !i_flush_valid) |-> valid_q[i_mem_done_id])
    else $warning("mem completion to invalid entry");

endmodule
